// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch (IF) and load/store (LS) requesters. Only one transaction is in flight
// at a time: accept in IDLE, strobe the memory in ISSUE, then wait MEM_LAT
// cycles. The read data is captured into a one-cycle response pulse for the
// requester that owned the transaction. LS normally has priority. A
// starvation counter forces an IF grant after STARVE_MAX LS wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_be,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [2:0]        wait_cnt_reg;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic              owner_ls_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [BE_W-1:0]   be_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              if_rsp_valid_reg, ls_rsp_valid_reg;
  logic [DATA_W-1:0] if_rsp_data_reg, ls_rsp_data_reg;

  logic idle, if_forced, grant_ls, grant_if;
  logic if_accept, ls_accept, last_wait;

  // Grant decision: LS wins ties unless IF has been starved for STARVE_MAX
  // LS grants. Ready is held low while rst is high so no request is accepted
  // by an edge that the reset will discard.
  assign idle      = (state_reg == IDLE);
  assign if_forced = if_req_valid && (starve_cnt_reg == CNT_W'(STARVE_MAX));
  assign grant_ls  = ls_req_valid && !if_forced;
  assign grant_if  = if_req_valid && !grant_ls;
  assign ls_accept = idle && !rst && grant_ls;
  assign if_accept = idle && !rst && grant_if;
  assign last_wait = (state_reg == WAIT) && (wait_cnt_reg == 3'd1);

  assign ls_req_ready = ls_accept;
  assign if_req_ready = if_accept;

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> IDLE sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (if_accept || ls_accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (last_wait) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and memory-latency countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ISSUE)
        wait_cnt_reg <= 3'(MEM_LAT);
      else if (state_reg == WAIT)
        wait_cnt_reg <= wait_cnt_reg - 3'd1;
    end
  end

  // Starvation counter: counts LS wins while IF is waiting and clears on IF grant.
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt_reg <= '0;
    else if (if_accept)
      starve_cnt_reg <= '0;
    else if (ls_accept && if_req_valid && (starve_cnt_reg != CNT_W'(STARVE_MAX)))
      starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
  end

  // Capture the accepted request. The held values double as the mem_* outputs,
  // so they persist between accesses and only mem_en qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_ls_reg <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      be_reg       <= '0;
      wdata_reg    <= '0;
    end else if (ls_accept) begin
      owner_ls_reg <= 1'b1;
      we_reg       <= ls_req_we;
      addr_reg     <= ls_req_addr;
      be_reg       <= ls_req_be;
      wdata_reg    <= ls_req_wdata;
    end else if (if_accept) begin
      owner_ls_reg <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= if_req_addr;
      be_reg       <= '1;
      wdata_reg    <= '0;
    end
  end

  // Response: sample mem_rdata at the edge that ends the last WAIT cycle and
  // pulse the owner's valid for one cycle. Writes answer with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rsp_valid_reg <= 1'b0;
      ls_rsp_valid_reg <= 1'b0;
      if_rsp_data_reg  <= '0;
      ls_rsp_data_reg  <= '0;
    end else begin
      if_rsp_valid_reg <= 1'b0;
      ls_rsp_valid_reg <= 1'b0;
      if (last_wait) begin
        if (owner_ls_reg) begin
          ls_rsp_valid_reg <= 1'b1;
          ls_rsp_data_reg  <= we_reg ? '0 : mem_rdata;
        end else begin
          if_rsp_valid_reg <= 1'b1;
          if_rsp_data_reg  <= mem_rdata;
        end
      end
    end
  end

  assign if_rsp_valid = if_rsp_valid_reg;
  assign if_rsp_data  = if_rsp_data_reg;
  assign ls_rsp_valid = ls_rsp_valid_reg;
  assign ls_rsp_data  = ls_rsp_data_reg;
  assign mem_en       = (state_reg == ISSUE);
  assign mem_we       = we_reg;
  assign mem_be       = be_reg;
  assign mem_addr     = addr_reg;
  assign mem_wdata    = wdata_reg;
  assign busy         = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. The main instance uses MEM_LAT=1 and runs
// against a behavioural memory. A second instance uses MEM_LAT=3 for the
// latency test. Expected responses come from a reference memory. They are
// pushed to a scoreboard at accept time and popped when a response pulse
// appears.
module tb_mem_port_arbiter;

  localparam int LAT  = 1;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance (MEM_LAT=1) ----------------
  logic        if_req_valid = 0, if_req_ready;
  logic [31:0] if_req_addr = 0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid = 0, ls_req_ready;
  logic [31:0] ls_req_addr = 0;
  logic        ls_req_we = 0;
  logic [31:0] ls_req_wdata = 0;
  logic [3:0]  ls_req_be = 0;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_en, mem_we, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- second instance (MEM_LAT=3) ----------------
  logic        rst3 = 1'b1;
  logic        if_req_valid3 = 0, if_req_ready3;
  logic [31:0] if_req_addr3 = 0;
  logic        if_rsp_valid3;
  logic [31:0] if_rsp_data3;
  logic        ls_req_valid3 = 0, ls_req_ready3;
  logic [31:0] ls_req_addr3 = 0;
  logic        ls_req_we3 = 0;
  logic [31:0] ls_req_wdata3 = 0;
  logic [3:0]  ls_req_be3 = 4'hF;
  logic        ls_rsp_valid3;
  logic [31:0] ls_rsp_data3;
  logic        mem_en3, mem_we3, busy3;
  logic [3:0]  mem_be3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .rst(rst3),
    .if_req_valid(if_req_valid3), .if_req_ready(if_req_ready3), .if_req_addr(if_req_addr3),
    .if_rsp_valid(if_rsp_valid3), .if_rsp_data(if_rsp_data3),
    .ls_req_valid(ls_req_valid3), .ls_req_ready(ls_req_ready3), .ls_req_addr(ls_req_addr3),
    .ls_req_we(ls_req_we3), .ls_req_wdata(ls_req_wdata3), .ls_req_be(ls_req_be3),
    .ls_rsp_valid(ls_rsp_valid3), .ls_rsp_data(ls_rsp_data3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0101 + ((i == 'h40) ? 32'h0 : 32'h0);
  endfunction

  // ---------------- memory models ----------------
  logic        mem_init = 1'b1;
  logic [31:0] sim_mem [256];
  logic [31:0] ref_mem [256];
  logic        rd_v = 1'b0;
  logic [31:0] rd_d = '0;

  // Memory behind the main DUT: one-cycle read latency. It shows junk whenever
  // no read result is due, so a mistimed sample returns the wrong data.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= (i == 'h40) ? 32'h13 : init_val(i);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sim_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_v <= mem_en && !mem_we;
    rd_d <= sim_mem[mem_addr[9:2]];
  end
  assign mem_rdata = rd_v ? rd_d : 32'hBAD0_BAD0;

  // Memory behind the MEM_LAT=3 DUT: data is a function of address, valid only
  // in the third cycle after mem_en.
  logic [2:0]  v3 = 3'b000;
  logic [31:0] d3 [3];
  always @(posedge clk) begin
    v3    <= {v3[1:0], mem_en3 && !mem_we3};
    d3[0] <= 32'hC0DE_0000 ^ mem_addr3;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign mem_rdata3 = v3[2] ? d3[2] : 32'hBAD0_BAD0;

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    bit          is_ls;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  bit          grant_log[$];
  int          last_acc_cyc = 0, prev_acc_cyc = 0;
  logic [31:0] l_addr = 0, l_wdata = 0;
  logic        l_we = 0;
  logic [3:0]  l_be = 0;

  // Sampling happens on the falling edge, half a cycle away from the DUT edge.
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = (i == 'h40) ? 32'h13 : init_val(i);
    end
    if (!rst) begin
      if (if_rsp_valid || ls_rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_owner", {62'd0, if_rsp_valid, ls_rsp_valid}, mon_e.is_ls ? 64'd1 : 64'd2);
          check("rsp_data", mon_e.is_ls ? ls_rsp_data : if_rsp_data, mon_e.data);
          check("rsp_cycle", cyc, mon_e.cyc);
          $display("rsp  cyc=%0d owner=%s data=%08h", cyc, mon_e.is_ls ? "LS" : "IF",
                   mon_e.is_ls ? ls_rsp_data : if_rsp_data);
        end
      end
      if (mem_en) begin
        check("mem_en_cycle", cyc, last_acc_cyc + 1);
        check("mem_addr", mem_addr, l_addr);
        check("mem_we_be", {mem_we, mem_be}, {l_we, l_be});
        check("mem_wdata", mem_wdata, l_wdata);
      end
      if (busy) check("ready_in_busy", {if_req_ready, ls_req_ready}, 2'b00);
      if (if_req_ready && ls_req_ready) check("dual_ready", 1, 0);
      if (ls_req_valid && ls_req_ready) begin
        prev_acc_cyc = last_acc_cyc;
        last_acc_cyc = cyc;
        l_addr = ls_req_addr; l_we = ls_req_we; l_be = ls_req_be; l_wdata = ls_req_wdata;
        mon_e.is_ls = 1'b1;
        mon_e.cyc   = cyc + LAT + 2;
        if (ls_req_we) begin
          for (int b = 0; b < 4; b++)
            if (ls_req_be[b]) ref_mem[ls_req_addr[9:2]][8*b +: 8] = ls_req_wdata[8*b +: 8];
          mon_e.data = 32'h0;
        end else begin
          mon_e.data = ref_mem[ls_req_addr[9:2]];
        end
        sb.push_back(mon_e);
        grant_log.push_back(1'b0);
        $display("acc  cyc=%0d LS addr=%08h we=%0b", cyc, ls_req_addr, ls_req_we);
      end else if (if_req_valid && if_req_ready) begin
        prev_acc_cyc = last_acc_cyc;
        last_acc_cyc = cyc;
        l_addr = if_req_addr; l_we = 1'b0; l_be = 4'hF; l_wdata = 32'h0;
        mon_e.is_ls = 1'b0;
        mon_e.cyc   = cyc + LAT + 2;
        mon_e.data  = ref_mem[if_req_addr[9:2]];
        sb.push_back(mon_e);
        grant_log.push_back(1'b1);
        $display("acc  cyc=%0d IF addr=%08h", cyc, if_req_addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Hold the selected valids until n accepts have occurred, then drop them.
  task automatic run_req(input int n, input bit en_if, input bit en_ls);
    int got = 0;
    int guard = 0;
    if_req_valid = en_if;
    ls_req_valid = en_ls;
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if ((if_req_valid && if_req_ready) || (ls_req_valid && ls_req_ready)) got++;
    end
    if (got < n) check("accept_timeout", got, n);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {56'd0, if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid,
                          mem_en, mem_we, busy, 1'b0}, 64'd0);
    check({tag, "_be"}, mem_be, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_rsp_data"}, {if_rsp_data, ls_rsp_data}, 0);
  endtask

  task automatic check_grants(input string tag, input int n, input int if_every);
    check({tag, "_count"}, grant_log.size(), n);
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), grant_log[i], ((i % if_every) == if_every - 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    mem_init = 1'b0;
    rst  = 1'b0;
    rst3 = 1'b0;

    // IF read of 0x100
    if_req_addr = 32'h0000_0100;
    run_req(1, 1'b1, 1'b0);
    drain();

    // LS partial write
    ls_req_addr = 32'h0000_2000; ls_req_we = 1'b1;
    ls_req_wdata = 32'hDEAD_BEEF; ls_req_be = 4'h3;
    run_req(1, 1'b0, 1'b1);
    drain();

    // Back-to-back LS reads of the written word
    ls_req_we = 1'b0; ls_req_be = 4'hF;
    run_req(2, 1'b0, 1'b1);
    drain();
    check("b2b_spacing", last_acc_cyc - prev_acc_cyc, LAT + 2);

    // Both requesters valid: starvation pattern
    grant_log.delete();
    if_req_addr = 32'h0000_0104;
    ls_req_addr = 32'h0000_0108;
    run_req(10, 1'b1, 1'b1);
    drain();
    check_grants("grant", 10, SMAX + 1);

    // Build up starvation, then reset during WAIT of an LS read
    run_req(2, 1'b1, 1'b1);
    drain();
    run_req(1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("busy_in_wait", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    grant_log.delete();
    run_req(5, 1'b1, 1'b1);
    drain();
    check_grants("post_rst", 5, SMAX + 1);
    if_req_addr = 32'h0000_0100;
    run_req(1, 1'b1, 1'b0);
    drain();

    // MEM_LAT=3 instance: LS read latency
    begin
      int guard = 0;
      ls_req_addr3  = 32'h0000_3000;
      ls_req_valid3 = 1'b1;
      @(negedge clk);
      while (!ls_req_ready3 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("lat3_accept", ls_req_ready3, 1);
      @(posedge clk); #1;
      ls_req_valid3 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        check($sformatf("lat3_mem_en_T%0d", k), mem_en3, (k == 1));
        check($sformatf("lat3_rsp_T%0d", k), {if_rsp_valid3, ls_rsp_valid3},
              (k == 5) ? 2'b01 : 2'b00);
        if (k == 5) check("lat3_rsp_data", ls_rsp_data3, 32'hC0DE_3000);
        $display("lat3 T+%0d mem_en=%0b ls_rsp_valid=%0b busy=%0b", k, mem_en3, ls_rsp_valid3, busy3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
